bitty_fetch: RTL and testbench
==============================

Name: bitty_fetch

Overview:
- Instruction fetch sequencer that sits directly upstream of bitty_core and drives its instruction and run inputs.
- Holds the program counter and reads 16-bit instructions from an external synchronous instruction memory.
- Presents each instruction to the core with a one-cycle run pulse, waits for the core's done, then advances the PC.
- Stops after a configurable last address, or on request.

Parameters:
- ADDR_W, 8, width of the PC and memory address.
- LAST_ADDR, 255, address of the final instruction; after it completes the block halts.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  level; begins or restarts execution from IDLE or HALT.
- stop  input  1  level; request to stop after the in-flight instruction.
- mem_rd_en  output  1  memory read strobe.
- mem_addr  output  ADDR_W  memory read address.
- mem_rdata  input  16  read data, valid exactly 1 cycle after mem_rd_en.
- instruction  output  16  instruction to the core, registered.
- run  output  1  one-cycle pulse telling the core to execute instruction.
- done  input  1  core completion pulse.
- pc  output  ADDR_W  current program counter.
- busy  output  1  high in FETCH, WAIT, ISSUE and EXEC.
- halted  output  1  high in HALT.
- instr_count  output  16  number of retired instructions.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, pc=0, instruction=0, instr_count=0.
  - run=0, mem_rd_en=0, mem_addr=0, halted=0, busy=0.
  - Reset mid-operation aborts immediately. A later done from the core is ignored because the state is IDLE.
- All outputs are registered or decoded from registered state. No combinational path from done or start to outputs.
- IDLE: when start=1, go to FETCH. Otherwise hold.
- FETCH (1 cycle): mem_rd_en=1, mem_addr=pc, then go to WAIT.
- WAIT (1 cycle): instruction <= mem_rdata, then go to ISSUE.
- ISSUE (1 cycle): run=1, then go to EXEC. instruction is stable from the WAIT capture until the next WAIT capture.
- EXEC: run=0; wait for done=1.
  - On done, increment instr_count (saturating at 0xFFFF).
  - If pc==LAST_ADDR: go to HALT; pc is unchanged.
  - Else if a stop request is latched: pc <= pc+1 and go to IDLE.
  - Else: pc <= pc+1 and go to FETCH.
- pc arithmetic is modulo 2^ADDR_W. Wrap occurs only if LAST_ADDR is 2^ADDR_W-1 and halting is bypassed, which it never is, so pc never wraps in operation.
- stop:
  - Sampled in every state. Sets a sticky stop_req flag, which is cleared on entry to IDLE.
  - In IDLE or HALT, stop has no effect.
  - stop and start asserted together in IDLE: start wins; stop_req is captured and takes effect after the first instruction.
- HALT:
  - halted=1.
  - On start=1: pc <= 0, instr_count <= 0, halted <= 0, go to FETCH.
- done handling:
  - done outside EXEC is ignored.
  - done in the same cycle as run (ISSUE) is ignored; the core never produces this.
- Minimum cycles per instruction: 4 (FETCH, WAIT, ISSUE, plus an EXEC cycle that sees done).

Test Plan:
- Reset then start:
  - Setup: mem[0]=0x1234, mem[1]=0xABCD, LAST_ADDR=1; done is returned 2 cycles after each run.
  - Required: mem_rd_en at addr 0; instruction=0x1234 before run; run pulses once.
  - Then addr 1 is read; instruction=0xABCD; after the second done, halted=1, pc=1, instr_count=2.
- Timing check:
  - Required: exactly 1 cycle from mem_rd_en to instruction update, and 1 more cycle to run.
  - run is never high for 2 consecutive cycles.
- stop during EXEC of the instruction at pc=3:
  - Required: after done, pc=4, state IDLE, busy=0, instr_count incremented by 1, no further mem_rd_en.
  - A subsequent start resumes with a fetch at addr 4.
- Spurious done:
  - Stimulus: done pulsed in IDLE, FETCH and WAIT.
  - Required: pc and instr_count are unchanged; no state skip occurs.
- Reset mid-EXEC (pc=5, instr_count=5):
  - Required: all outputs return to 0 asynchronously, before the next clock edge.
  - A done arriving afterwards is ignored.
- Restart from HALT:
  - Stimulus: start=1 while halted=1.
  - Required: next cycle pc=0, instr_count=0, halted=0, mem_rd_en=1 with addr 0.

Source files
------------

// File: rtl/bitty_fetch.sv
`default_nettype none
// ============================================================================
// Module      : bitty_fetch
// Description : Instruction fetch sequencer for bitty_core. Holds the PC,
//               reads 16-bit instructions from a synchronous instruction
//               memory, hands each one to the core with a one-cycle run
//               pulse, waits for done and then advances. Halts after
//               LAST_ADDR completes, or returns to IDLE on a stop request.
// Ports       : clk, reset (async, active-low)
//               start, stop            - control levels
//               mem_rd_en, mem_addr    - memory read request
//               mem_rdata              - read data, one cycle after request
//               instruction, run, done - core handshake
//               pc, busy, halted, instr_count - status
// Revision    : 1.0 - initial release
// ============================================================================
module bitty_fetch #(
    parameter int ADDR_W    = 8,
    parameter int LAST_ADDR = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       instruction,
    output logic              run,
    input  logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic [15:0]       instr_count
);

    localparam logic [ADDR_W-1:0] c_last_pc = ADDR_W'(LAST_ADDR);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_EXEC  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [15:0]       count_q, count_d;
    logic              stop_req_q, stop_req_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            count_q    <= '0;
            stop_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            count_q    <= count_d;
            stop_req_q <= stop_req_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        count_d    = count_q;
        // Sticky: any stop seen while running is remembered until IDLE.
        stop_req_d = stop_req_q | stop;

        case (state_q)
            S_IDLE: begin
                // A stop that arrives together with start is kept so the
                // block runs exactly one instruction and returns here.
                stop_req_d = 1'b0;
                if (start) begin
                    state_d    = S_FETCH;
                    stop_req_d = stop;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                instr_d = mem_rdata;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // done here is ignored; the core cannot finish in the run cycle.
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (done) begin
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    if (pc_q == c_last_pc) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                        if (stop_req_q || stop) begin
                            state_d    = S_IDLE;
                            stop_req_d = 1'b0;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_HALT: begin
                stop_req_d = 1'b0;
                if (start) begin
                    pc_d       = '0;
                    count_d    = '0;
                    state_d    = S_FETCH;
                    stop_req_d = stop;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Every output is a flop or a pure decode of the state register.
    assign mem_rd_en   = (state_q == S_FETCH);
    assign mem_addr    = pc_q;
    assign run         = (state_q == S_ISSUE);
    assign busy        = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                         (state_q == S_ISSUE) || (state_q == S_EXEC);
    assign halted      = (state_q == S_HALT);
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_bitty_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitty_fetch
// Description : Scoreboard bench for bitty_fetch. The sequence pushes the
//               expected (address, instruction) of every fetch it intends;
//               a monitor pops and compares on each fetch/run. Includes a
//               synchronous memory model and a core model returning done
//               two cycles after run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitty_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = 16'h0;
    logic [15:0] instruction;
    logic        run;
    logic        core_done = 1'b0;
    logic        tb_done = 1'b0;
    logic        done_in;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic [15:0] instr_count;

    logic [15:0] mem [0:255];

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] instr;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fetch_cyc = 0;
    int hold_addr = -1;
    logic prev_run = 1'b0;

    assign done_in = core_done | tb_done;

    bitty_fetch #(
        .ADDR_W    (8),
        .LAST_ADDR (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .run         (run),
        .done        (done_in),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            exp_t e;
            e.addr  = 8'(a);
            e.instr = mem[a];
            exp_q.push_back(e);
        end
    endtask

    // Core model: done two cycles after run, except at hold_addr.
    initial forever begin
        @(negedge clk);
        if (reset && run && (int'(pc) != hold_addr)) begin
            @(posedge clk); #1;
            @(posedge clk); #1 core_done = 1'b1;
            @(posedge clk); #1 core_done = 1'b0;
        end
    end

    // Scoreboard monitor.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            if (mem_rd_en) begin
                check("fetch_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("fetch_addr", 32'(mem_addr), 32'(exp_q[0].addr));
                fetch_cyc = cyc;
            end
            if (run) begin
                check("run_single_cycle", 32'(prev_run), 0);
                check("run_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("instr_at_run", 32'(instruction), 32'(exp_q[0].instr));
                    check("fetch_to_run_cycles", 32'(cyc - fetch_cyc), 2);
                    void'(exp_q.pop_front());
                end
            end
            prev_run = run;
        end else begin
            prev_run = 1'b0;
        end
    end

    task automatic wait_run_pc(input logic [7:0] p, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(run && pc == p) && n < 60);
        check(name, 32'(run && pc == p), 1);
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!halted && n < 100);
        check(name, 32'(halted), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 40);
        check(name, 32'(busy), 0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_seen;
        mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0F0F; mem[3] = 16'h5A5A;
        mem[4] = 16'hC3C3; mem[5] = 16'h7777; mem[6] = 16'h0001; mem[7] = 16'hFFFF;
        for (int a = 8; a < 256; a++) mem[a] = 16'(a * 3);

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_pc", 32'(pc), 0);
        check("rst_instruction", 32'(instruction), 0);
        check("rst_instr_count", 32'(instr_count), 0);
        check("rst_flags", {28'd0, run, mem_rd_en, busy, halted}, 0);
        check("rst_mem_addr", 32'(mem_addr), 0);

        // Run 0..3, stop during EXEC of pc=3
        push_range(0, 3);
        pulse_start();
        wait_run_pc(8'd3, "reach_run_pc3");
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_idle("stop_to_idle");
        check("stop_pc", 32'(pc), 4);
        check("stop_count", 32'(instr_count), 4);
        check("stop_halted", 32'(halted), 0);
        rd_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_rd_en) rd_seen++;
        end
        check("stop_no_fetch", 32'(rd_seen), 0);

        // Spurious done in IDLE
        @(posedge clk); #1 tb_done = 1'b1;
        @(posedge clk); #1 tb_done = 1'b0;
        @(negedge clk);
        check("idle_done_pc", 32'(pc), 4);
        check("idle_done_count", 32'(instr_count), 4);
        check("idle_done_busy", 32'(busy), 0);

        // Resume at 4, spurious done in FETCH and WAIT; core holds at pc=5
        hold_addr = 5;
        push_range(4, 5);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; tb_done = 1'b1;
        check("resume_fetch", 32'(mem_rd_en), 1);
        @(posedge clk); #1;
        check("wait_no_skip", {30'd0, run, mem_rd_en}, 0);
        @(posedge clk); #1 tb_done = 1'b0;
        check("issue_after_wait", 32'(run), 1);
        check("spurious_pc", 32'(pc), 4);
        check("spurious_count", 32'(instr_count), 4);

        // Reset mid-EXEC at pc=5
        wait_run_pc(8'd5, "reach_run_pc5");
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("exec5_pc", 32'(pc), 5);
        check("exec5_count", 32'(instr_count), 5);
        check("exec5_busy", 32'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_pc", 32'(pc), 0);
        check("async_rst_count", 32'(instr_count), 0);
        check("async_rst_instr", 32'(instruction), 0);
        check("async_rst_flags", {28'd0, run, mem_rd_en, busy, halted}, 0);
        check("async_rst_addr", 32'(mem_addr), 0);
        @(posedge clk); #1 reset = 1'b1; tb_done = 1'b1;
        @(posedge clk); #1 tb_done = 1'b0;
        @(negedge clk);
        check("late_done_busy", 32'(busy), 0);
        check("late_done_count", 32'(instr_count), 0);
        check("late_done_pc", 32'(pc), 0);
        hold_addr = -1;

        // Full run to LAST_ADDR
        push_range(0, 7);
        pulse_start();
        wait_halt("run_to_halt");
        check("halt_pc", 32'(pc), 7);
        check("halt_count", 32'(instr_count), 8);
        check("halt_instr", 32'(instruction), 32'h0000FFFF);
        check("halt_busy", 32'(busy), 0);

        // Restart from HALT
        push_range(0, 7);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("restart_pc", 32'(pc), 0);
        check("restart_count", 32'(instr_count), 0);
        check("restart_halted", 32'(halted), 0);
        check("restart_rd_en", 32'(mem_rd_en), 1);
        check("restart_addr", 32'(mem_addr), 0);
        wait_halt("rerun_to_halt");
        check("rerun_count", 32'(instr_count), 8);
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
